// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write arbiter: FSM state, level width and the
// round-robin search used by rr_pick.
package fifo_write_arbiter_pkg;

   typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_t;

   localparam int rr_max = 32;

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // First set bit after 'last', wrapping at n; -1 when nothing requests.
   function automatic int rr_next(input logic [rr_max-1:0] req, input int n, input int last);
      int pick;
      int idx;
      pick = -1;
      for (int k = 1; k <= rr_max; k++) begin
         idx = last + k;
         if (idx >= n) idx = idx - n;
         if (k <= n && pick < 0 && req[idx[4:0]]) pick = idx;
      end
      return pick;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after last_owner, with wrap.
module rr_pick
   import fifo_write_arbiter_pkg::*;
#(
   parameter int num_requesters = 4
) (
   input  logic [num_requesters-1:0]         req,
   input  logic [$clog2(num_requesters)-1:0] last_owner,
   output logic                              found,
   output logic [$clog2(num_requesters)-1:0] index
);

   localparam int iw = $clog2(num_requesters);

   logic [rr_max-1:0] req_ext;
   int                pick;

   always_comb begin
      req_ext                      = '0;
      req_ext[num_requesters-1:0]  = req;
      pick                         = rr_next(req_ext, num_requesters, int'(last_owner));
      found                        = (pick >= 0);
      index                        = pick[iw-1:0];
   end

endmodule

// File: rtl/generic_fifo.sv
// Single-clock FIFO with registered write, registered read data (data_valid one cycle after
// read_enable) and registered full/empty flags; depth must be a power of two.
module generic_fifo #(
   parameter int data_width = 16,
   parameter int data_depth = 256
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic [data_width-1:0] data_in,
   input  logic                  read_enable,
   output logic [data_width-1:0] data_out,
   output logic                  data_valid,
   output logic                  full,
   output logic                  empty
);

   localparam int aw = $clog2(data_depth);
   localparam int cw = aw + 1;

   logic [data_width-1:0] mem [data_depth];
   logic [aw-1:0]         wr_ptr;
   logic [aw-1:0]         rd_ptr;
   logic [cw-1:0]         count;
   logic [cw-1:0]         count_next;
   logic                  do_write;
   logic                  do_read;

   assign do_write = write_enable && !full;
   assign do_read  = read_enable && !empty;

   always_comb begin
      count_next = count + cw'(do_write) - cw'(do_read);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + aw'(1);
         if (do_read) begin
            rd_ptr   <= rd_ptr + aw'(1);
            data_out <= mem[rd_ptr];
         end
         data_valid <= do_read;
         count      <= count_next;
         full       <= (count_next == cw'(data_depth));
         empty      <= (count_next == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (do_write) mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of a generic_fifo write port; ack is combinational, write lands one cycle
// after ack, and ack is held off while the private level count leaves no room.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int num_requesters = 4,
   parameter int data_width     = 16,
   parameter int data_depth     = 256,
   parameter int max_burst      = 8
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [num_requesters-1:0]            req,
   input  logic [num_requesters*data_width-1:0] req_data,
   output logic [num_requesters-1:0]            ack,
   output logic [num_requesters-1:0]            grant,
   input  logic                                 rd_req,
   output logic                                 fifo_write_enable,
   output logic [data_width-1:0]                fifo_data_in,
   output logic                                 fifo_read_enable,
   output logic [level_width(data_depth)-1:0]   level,
   output logic                                 busy
);

   localparam int iw = $clog2(num_requesters);
   localparam int lw = level_width(data_depth);
   localparam int bw = $clog2(max_burst + 1);
   // One entry of margin so the FIFO's registered size compare never sees it full.
   localparam logic [lw:0]    space_limit = (lw + 1)'(data_depth - 1);
   localparam logic [bw-1:0]  burst_last  = bw'(max_burst);
   localparam logic [iw-1:0]  owner_reset = iw'(num_requesters - 1);

   state_t                state;
   logic [iw-1:0]         owner;
   logic [iw-1:0]         last_owner;
   logic [bw-1:0]         beats;
   logic [bw-1:0]         beats_next;
   logic                  pick_found;
   logic [iw-1:0]         pick_index;
   logic [lw:0]           level_sum;
   logic                  has_space;
   logic                  owner_req;
   logic                  accept;
   logic [data_width-1:0] owner_data;

   rr_pick #(.num_requesters(num_requesters)) u_rr_pick (
      .req        (req),
      .last_owner (last_owner),
      .found      (pick_found),
      .index      (pick_index)
   );

   always_comb begin
      level_sum  = {1'b0, level} + {{lw{1'b0}}, fifo_write_enable};
      has_space  = (level_sum < space_limit);
      owner_req  = req[owner];
      owner_data = req_data[int'(owner) * data_width +: data_width];
      accept     = (state == OWN) && owner_req && has_space;
      beats_next = beats + bw'(1);
      ack        = '0;
      if (accept) ack[owner] = 1'b1;
   end

   assign fifo_read_enable = rd_req && (level != '0);
   assign busy             = (state == OWN);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         owner             <= '0;
         last_owner        <= owner_reset;
         beats             <= '0;
         grant             <= '0;
         fifo_write_enable <= 1'b0;
         fifo_data_in      <= '0;
         level             <= '0;
      end else begin
         fifo_write_enable <= accept;
         if (accept) fifo_data_in <= owner_data;
         level <= level + lw'(fifo_write_enable) - lw'(fifo_read_enable);

         case (state)
            IDLE: begin
               if (pick_found) begin
                  state <= OWN;
                  owner <= pick_index;
                  beats <= '0;
                  grant <= {{(num_requesters-1){1'b0}}, 1'b1} << pick_index;
               end
            end
            OWN: begin
               if (!owner_req) begin
                  state      <= IDLE;
                  last_owner <= owner;
                  grant      <= '0;
               end else if (has_space) begin
                  beats <= beats_next;
                  if (beats_next == burst_last) begin
                     state      <= IDLE;
                     last_owner <= owner;
                     grant      <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter driving a generic_fifo: vector table, directed corner
// sequences and a randomized run checked against per-producer in-order delivery.
module tb_fifo_write_arbiter;

   localparam int n_req = 4;
   localparam int dw    = 16;
   localparam int depth = 16;
   localparam int mb    = 8;
   localparam int lw    = 5;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [n_req-1:0]  req;
   logic [n_req*dw-1:0] req_data;
   logic [dw-1:0]     pdata [n_req];
   logic [n_req-1:0]  ack;
   logic [n_req-1:0]  grant;
   logic              rd_req;
   logic              fifo_write_enable;
   logic [dw-1:0]     fifo_data_in;
   logic              fifo_read_enable;
   logic [lw-1:0]     level;
   logic              busy;
   logic [dw-1:0]     data_out;
   logic              data_valid;
   logic              full;
   logic              empty;

   int tests = 0;
   int fails = 0;
   int full_cycles = 0;

   typedef struct packed {
      logic [3:0]  req;
      logic [15:0] d;
      logic        rd;
      logic [3:0]  grant;
      logic [3:0]  ack;
      logic        we;
      logic        re;
      logic        busy;
      logic [4:0]  level;
      logic        dv;
      logic [15:0] dout;
   } vec_t;

   vec_t        vt [15];
   logic [32:0] obs;
   logic [32:0] expv;
   int          cnt, beats, bub, sent, rcv, lchk, want, rcvd, base;
   logic        started, legal;
   logic [1:0]  id;
   logic [3:0]  acked;
   int          total [n_req];
   int          psent [n_req];
   int          rexp  [n_req];

   always #5 clock = ~clock;

   always_comb begin
      for (int i = 0; i < n_req; i++) req_data[i*dw +: dw] = pdata[i];
   end

   always @(negedge clock) if (full) full_cycles++;

   fifo_write_arbiter #(
      .num_requesters (n_req),
      .data_width     (dw),
      .data_depth     (depth),
      .max_burst      (mb)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .req               (req),
      .req_data          (req_data),
      .ack               (ack),
      .grant             (grant),
      .rd_req            (rd_req),
      .fifo_write_enable (fifo_write_enable),
      .fifo_data_in      (fifo_data_in),
      .fifo_read_enable  (fifo_read_enable),
      .level             (level),
      .busy              (busy)
   );

   generic_fifo #(.data_width(dw), .data_depth(depth)) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .write_enable (fifo_write_enable),
      .data_in      (fifo_data_in),
      .read_enable  (fifo_read_enable),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .full         (full),
      .empty        (empty)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      req    = '0;
      rd_req = 1'b0;
      for (int i = 0; i < n_req; i++) pdata[i] = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic row(input int r, input logic [3:0] rq, input logic [15:0] d, input logic rd,
                      input logic [3:0] g, input logic [3:0] a, input logic we, input logic re,
                      input logic bz, input logic [4:0] lv, input logic dv, input logic [15:0] dout);
      vt[r] = '{rq, d, rd, g, a, we, re, bz, lv, dv, dout};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Single producer on requester 2, then drain including reads on an empty FIFO.
      row( 0, 4'b0100, 16'h0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0000);
      row( 1, 4'b0100, 16'h0100, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 16'h0000);
      row( 2, 4'b0100, 16'h0101, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 16'h0000);
      row( 3, 4'b0100, 16'h0102, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 16'h0000);
      row( 4, 4'b0100, 16'h0103, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 16'h0000);
      row( 5, 4'b0100, 16'h0104, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 16'h0000);
      row( 6, 4'b0000, 16'h0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 16'h0000);
      row( 7, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 16'h0000);
      row( 8, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 16'h0000);
      row( 9, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 16'h0100);
      row(10, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 16'h0101);
      row(11, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1, 16'h0102);
      row(12, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 16'h0103);
      row(13, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 16'h0104);
      row(14, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0000);

      // Reset state, with requests and reads pushing on the inputs.
      reset  = 1'b1;
      req    = 4'b1111;
      rd_req = 1'b1;
      for (int i = 0; i < n_req; i++) pdata[i] = 16'hffff;
      @(negedge clock);
      check("reset_grant_ack", 64'({grant, ack}), 64'd0);
      check("reset_write", 64'({fifo_write_enable, fifo_data_in}), 64'd0);
      check("reset_level_busy", 64'({level, busy, fifo_read_enable}), 64'd0);
      check("reset_fifo_empty", 64'(empty), 64'd1);

      do_reset();
      for (int r = 0; r < 15; r++) begin
         req    = vt[r].req;
         rd_req = vt[r].rd;
         for (int i = 0; i < n_req; i++) pdata[i] = vt[r].d;
         @(negedge clock);
         obs  = {grant, ack, fifo_write_enable, fifo_read_enable, busy, level, data_valid,
                 vt[r].dv ? data_out : 16'h0000};
         expv = {vt[r].grant, vt[r].ack, vt[r].we, vt[r].re, vt[r].busy, vt[r].level,
                 vt[r].dv, vt[r].dout};
         check($sformatf("vec%0d", r), 64'(obs), 64'(expv));
         next_cycle();
      end

      // Round-robin fairness with all producers requesting.
      do_reset();
      req    = 4'b1111;
      rd_req = 1'b1;
      @(negedge clock);
      for (int g = 0; g < 5; g++) begin
         cnt = 0;
         while (grant == 4'b0000 && cnt < 20) begin
            @(negedge clock);
            cnt++;
         end
         check($sformatf("rr_grant%0d", g), 64'(grant), 64'(4'b0001 << (g % 4)));
         beats = 0;
         cnt   = 0;
         while (grant != 4'b0000 && cnt < 20) begin
            if (ack == grant) beats++;
            @(negedge clock);
            cnt++;
         end
         check($sformatf("rr_beats%0d", g), 64'(beats), 64'(mb));
         if (g < 4) begin
            bub = 0;
            while (grant == 4'b0000 && bub < 20) begin
               bub++;
               @(negedge clock);
            end
            check($sformatf("rr_bubble%0d", g), 64'(bub), 64'd1);
         end
      end
      next_cycle();

      // Back-pressure with no reads.
      do_reset();
      base     = full_cycles;
      req      = 4'b0001;
      pdata[0] = 16'h0300;
      repeat (40) @(negedge clock);
      check("bp_level", 64'(level), 64'd15);
      check("bp_ack_held", 64'(ack), 64'd0);
      check("bp_grant_held", 64'(grant), 64'(4'b0001));
      next_cycle();
      rd_req = 1'b1;
      @(negedge clock);
      check("bp_read", 64'(fifo_read_enable), 64'd1);
      next_cycle();
      rd_req = 1'b0;
      @(negedge clock);
      check("bp_level_after", 64'(level), 64'd14);
      check("bp_ack_resume", 64'(ack), 64'(4'b0001));
      check("bp_no_full", 64'(full_cycles - base), 64'd0);
      next_cycle();

      // Simultaneous read and write around level 3.
      do_reset();
      sent = 0; rcv = 0; lchk = 0; started = 1'b0;
      for (int cyc = 0; cyc < 120; cyc++) begin
         if (!started && level == 5'd3) begin
            started = 1'b1;
            rd_req  = 1'b1;
         end
         req[1]   = (sent < 20);
         pdata[1] = 16'h0200 + 16'(sent);
         @(negedge clock);
         if (started && lchk < 5) begin
            check("simul_level", 64'(level), 64'd3);
            lchk++;
         end
         if (ack[1]) sent++;
         if (data_valid) begin
            if (rcv < 20) check("simul_data", 64'(data_out), 64'(16'h0200 + 16'(rcv)));
            rcv++;
         end
         next_cycle();
      end
      check("simul_level_checks", 64'(lchk), 64'd5);
      check("simul_count", 64'(rcv), 64'd20);

      // Reset in the middle of a burst.
      do_reset();
      req      = 4'b0010;
      pdata[1] = 16'h0400;
      beats    = 0;
      for (int cyc = 0; cyc < 20 && beats < 4; cyc++) begin
         @(negedge clock);
         if (ack[1]) beats++;
         if (beats < 4) next_cycle();
      end
      check("rst_mid_beats", 64'(beats), 64'd4);
      reset = 1'b1;
      #1;
      check("rst_mid_outputs", 64'({grant, level, fifo_write_enable, busy}), 64'd0);
      @(posedge clock);
      #1;
      reset    = 1'b0;
      req      = 4'b0011;
      pdata[0] = 16'h0500;
      @(negedge clock);
      check("rst_idle", 64'(grant), 64'd0);
      next_cycle();
      @(negedge clock);
      check("rst_first_grant", 64'(grant), 64'(4'b0001));
      next_cycle();

      // Randomized producers and consumer; each producer's words must arrive in order.
      do_reset();
      base  = full_cycles;
      want  = 0;
      rcvd  = 0;
      acked = '0;
      for (int i = 0; i < n_req; i++) begin
         total[i] = $urandom_range(10, 40);
         psent[i] = 0;
         rexp[i]  = 0;
         want    += total[i];
      end
      for (int cyc = 0; cyc < 6000 && rcvd < want; cyc++) begin
         for (int i = 0; i < n_req; i++) begin
            if (!(req[i] && !acked[i]))
               req[i] = (psent[i] < total[i]) && ($urandom_range(0, 3) != 0);
            pdata[i] = {i[1:0], 2'b00, 12'(psent[i])};
         end
         rd_req = ($urandom_range(0, 2) != 0);
         @(negedge clock);
         legal = ((ack & ~req) == 4'b0000) && $onehot0(ack);
         check("rand_ack_legal", 64'(legal), 64'd1);
         acked = ack;
         for (int i = 0; i < n_req; i++) if (ack[i]) psent[i]++;
         if (data_valid) begin
            id = data_out[15:14];
            check("rand_order", 64'(data_out), 64'({id, 2'b00, 12'(rexp[id])}));
            rexp[id]++;
            rcvd++;
         end
         next_cycle();
      end
      check("rand_total", 64'(rcvd), 64'(want));
      check("rand_no_full", 64'(full_cycles - base), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares the single write port of a `generic_fifo` instance among `num_requesters` producers. It also gates the consumer's read requests onto the FIFO read port. It keeps its own occupancy count, so it never relies on the FIFO's registered `full`/`empty` flags, which lag by one cycle. It sits directly in front of the FIFO, and its write and read outputs drive the FIFO inputs unmodified.

## Interface
- `num_requesters`, 4: number of producers, at least 2.
- `data_width`, 16: word width; must match the FIFO.
- `data_depth`, 256: FIFO depth; must match the FIFO.
- `max_burst`, 8: maximum accepted beats per grant, at least 1.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  num_requesters  per-producer request, held until acked.
- `req_data`  in  num_requesters*data_width  producer i's data in slice [i*data_width +: data_width].
- `ack`  out  num_requesters  combinational; beat accepted this cycle.
- `grant`  out  num_requesters  registered one-hot owner; all zero when idle.
- `rd_req`  in  1  consumer read request.
- `fifo_write_enable`  out  1  registered; drives FIFO `write_enable`.
- `fifo_data_in`  out  data_width  registered; drives FIFO `data_in`.
- `fifo_read_enable`  out  1  combinational; drives FIFO `read_enable`.
- `level`  out  clog2(data_depth)+1  entries committed into the FIFO.
- `busy`  out  1  state is OWN.

## Operation
- States:
  - IDLE: no owner.
  - OWN: `owner` register valid; `beats` counter runs 0..max_burst.
- IDLE → OWN:
  - Taken when any `req` is high.
  - The new owner is the first requester with `req` high, searching from `last_owner`+1 upward with wrap.
  - `beats` is set to 0.
  - If no `req` is high, the state stays IDLE.
- `has_space` = (`level` + `fifo_write_enable`) < `data_depth`-1. The one-entry margin covers the FIFO's registered size compare.
- In OWN, `ack[owner]` = `req[owner]` & `has_space`. All other `ack` bits are 0, and `ack` is always 0 in IDLE.
- On ack:
  - `fifo_write_enable` is set to 1 and `fifo_data_in` is loaded with `req_data[owner]`.
  - `beats` increments.
  - If the incremented `beats` equals `max_burst`, the state moves to IDLE and `last_owner` is set to `owner`.
- OWN with `req[owner]` low: the state moves to IDLE and `last_owner` is set to `owner`; no beat is accepted.
- OWN with `req[owner]` high but `has_space` low: the arbiter stalls and holds ownership; `beats` is unchanged.
- Without an ack, `fifo_write_enable` is 0 the next cycle. `fifo_data_in` holds its last value.
- `fifo_read_enable` = `rd_req` & (`level` != 0).
- `level` next value = `level` + `fifo_write_enable` − `fifo_read_enable`. A simultaneous increment and decrement leaves it unchanged.
- `level` width is clog2(data_depth)+1. By construction it never exceeds `data_depth`-1 and never underflows.

## Timing
- Reset values:
  - `grant`=0, `fifo_write_enable`=0, `fifo_data_in`=0, `level`=0, `busy`=0.
  - State IDLE, `last_owner`=num_requesters-1, so requester 0 has first priority.
  - `ack`=0 and `fifo_read_enable`=0 follow combinationally.
- Arbitration latency: a request arriving while IDLE is acked no earlier than the next cycle.
- Every grant ends with one IDLE bubble cycle.
- Ack-to-write latency is 1 cycle: the `fifo_write_enable` pulse follows the ack cycle.
- A committed word is readable (`level`>0) 2 cycles after its ack. This matches the FIFO's registered write.
- `fifo_read_enable` is gated by `level`, so the FIFO never sees a read on an empty array. The FIFO's `data_valid` follows 1 cycle after each gated read.
- Reset mid-burst:
  - Everything returns to reset values immediately.
  - An in-flight `fifo_write_enable` is dropped.
  - The FIFO must be reset on the same `reset`.
- A producer dropping `req` mid-burst is legal. A producer must not change `req_data` while `req` is high and unacked.

## Structure
- Shared package: round-robin next-owner function (one-hot/index search with wrap), `level` width constant clog2(data_depth)+1, and the state enum {IDLE, OWN}.
- One natural sub-module, `rr_pick`: combinational round-robin selector with inputs `req` and `last_owner`, outputs `found` and `index`. It is reusable for a future read-side scheduler.
- A testbench instantiates `fifo_write_arbiter` plus `generic_fifo` together.

## Test plan
- **Single producer.** num_requesters=4, max_burst=8, req[2] held with data 0x0100..0x0104.
  - grant=0b0100 one cycle after req.
  - 5 acks, then req drops; state goes to IDLE.
  - level reaches 5; consumer reads return 0x0100..0x0104 in order.
- **Round-robin fairness.** All four req held continuously.
  - Grants cycle 0,1,2,3,0.
  - Each grant delivers exactly 8 beats, then one IDLE bubble.
- **Back-pressure.** data_depth=16 with no reads.
  - After 15 commits, ack stays 0 and grant holds.
  - One rd_req cycle → level=14 → the next ack occurs.
  - FIFO `full` is never asserted.
- **Simultaneous read and write.** level=3, rd_req held while writing at 1 beat/cycle.
  - level stays 3.
  - Data out is in exact write order with no duplicates or losses.
- **Empty read.** level=0, rd_req=1.
  - fifo_read_enable=0; FIFO data_valid stays 0.
- **Reset mid-burst.** reset asserted at beat 4 of a req[1] grant.
  - grant=0, level=0, fifo_write_enable=0 in the same cycle.
  - After release with req[1] and req[0] high, req[0] is granted first.
